frame_buffer_scheduler: RTL and testbench

//  Sequences the layer mixer and shares the two framebuffers (ping-pong) between mixer writes and
//  ST7789 display readout. Generates the mixer frame start from a refresh interval, picks a FREE

---
 rtl/mixer_pkg.sv | 33 +++
 rtl/frame_tick_gen.sv | 39 +++
 rtl/frame_buffer_scheduler.sv | 159 +++++++++++++++
 tb/tb_frame_buffer_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared types and sizing helpers for the framebuffer scheduler and its tick generator.
package mixer_pkg;

    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_WRITING = 2'd1,
        BUF_READY   = 2'd2,
        BUF_READING = 2'd3
    } buf_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_t;

    function automatic int calc_addr_w(input int x_lim, input int y_lim);
        return $clog2(x_lim) + $clog2(y_lim);
    endfunction

    function automatic int calc_pixel_limit(input int x_lim, input int y_lim);
        return x_lim * y_lim;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Refresh interval counter: raises a pending request on every terminal count and counts
// ticks that arrive while an earlier request is still unserved.
module frame_tick_gen
    import mixer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] i_update_limit,
    input  logic        i_consume,
    output logic        o_pending,
    output logic [15:0] o_skip_count
);

    logic [31:0] r_count;
    logic        r_pending;
    logic [15:0] r_skip_count;
    logic        w_tick;

    // >= keeps the counter from running away if the limit is lowered mid-interval
    assign w_tick = (i_update_limit <= 32'd1) || (r_count >= i_update_limit - 32'd1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count      <= '0;
            r_pending    <= 1'b0;
            r_skip_count <= '0;
        end else begin
            r_count   <= w_tick ? '0 : r_count + 32'd1;
            r_pending <= w_tick | (r_pending & ~i_consume);
            if (w_tick && r_pending && !i_consume) begin
                r_skip_count <= sat_inc16(r_skip_count);
            end
        end
    end

    assign o_pending    = r_pending;
    assign o_skip_count = r_skip_count;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong framebuffer scheduler: paces mixer passes from a refresh tick, freezes layer
// enables per pass with eye blinking, and hands finished frames to the display by REQ/ACK.
module frame_buffer_scheduler
    import mixer_pkg::*;
#(
    parameter  int X_LIMIT      = 240,
    parameter  int Y_LIMIT      = 240,
    parameter  int BLINK_PERIOD = 32,
    parameter  int BLINK_OFF    = 3,
    localparam int ADDR_W       = calc_addr_w(X_LIMIT, Y_LIMIT)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       UPDATE_LIMIT,
    input  logic [3:0]        LAYER_CONTROL_REQ,
    output logic              MIX_START,
    output logic [3:0]        LAYER_CONTROL,
    input  logic              MIX_WRITE,
    input  logic [ADDR_W-1:0] MIX_ADDRESS,
    output logic              WR_BUF_SEL,
    input  logic              DISP_FRAME_REQ,
    output logic              DISP_FRAME_ACK,
    output logic              RD_BUF_SEL,
    input  logic              DISP_FRAME_DONE,
    output logic [15:0]       FRAME_COUNT,
    output logic [15:0]       DROP_COUNT,
    output logic [15:0]       SKIP_COUNT
);

    localparam int                PIXEL_LIMIT = calc_pixel_limit(X_LIMIT, Y_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(PIXEL_LIMIT - 1);
    localparam int                BLINK_W     = $clog2(BLINK_PERIOD);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_PERIOD - 1);
    localparam logic [BLINK_W-1:0] BLINK_OFF_N = BLINK_W'(BLINK_OFF);

    wr_state_t          r_wr_state, w_wr_state_next;
    rd_state_t          r_rd_state, w_rd_state_next;
    logic [1:0]         w_free, w_ready;
    logic               w_pending;
    logic               w_start, w_start_buf, w_complete, w_drop;
    logic               w_grant, w_grant_buf, w_release;
    logic               w_blink_off;
    logic [3:0]         w_layer_frozen;
    logic               r_wr_buf, r_rd_buf, r_ack;
    logic [3:0]         r_layer;
    logic [BLINK_W-1:0] r_blink_idx;
    logic [15:0]        r_frame_count, r_drop_count, w_skip_count;

    frame_tick_gen u_tick (
        .CLK            (CLK),
        .RESET          (RESET),
        .i_update_limit (UPDATE_LIMIT),
        .i_consume      (w_start),
        .o_pending      (w_pending),
        .o_skip_count   (w_skip_count)
    );

    // Every decision below reads registered buffer states only, so a buffer freed or
    // filled this cycle is first visible to the other side on the next cycle.
    assign w_start     = (r_wr_state == W_IDLE) && w_pending && (w_free != 2'b00);
    assign w_start_buf = ~w_free[0];
    assign w_complete  = (r_wr_state == W_BUSY) && MIX_WRITE && (MIX_ADDRESS == LAST_ADDR);
    assign w_grant     = (r_rd_state == R_IDLE) && DISP_FRAME_REQ && (w_ready != 2'b00);
    assign w_grant_buf = w_ready[1];
    assign w_release   = (r_rd_state == R_BUSY) && DISP_FRAME_DONE;
    // A READY frame being granted this very cycle is owned by the display, not dropped
    assign w_drop      = w_complete && w_ready[~r_wr_buf] && !w_grant;

    assign w_blink_off    = (r_blink_idx < BLINK_OFF_N);
    assign w_layer_frozen = {LAYER_CONTROL_REQ[3], LAYER_CONTROL_REQ[2] & ~w_blink_off,
                             LAYER_CONTROL_REQ[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            buf_state_t r_state, w_state_next;

            always_comb begin
                w_state_next = r_state;
                if (w_start && (w_start_buf == 1'(gi)))   w_state_next = BUF_WRITING;
                if (w_complete && (r_wr_buf == 1'(gi)))   w_state_next = BUF_READY;
                if (w_drop && (r_wr_buf != 1'(gi)))       w_state_next = BUF_FREE;
                if (w_grant && (w_grant_buf == 1'(gi)))   w_state_next = BUF_READING;
                if (w_release && (r_rd_buf == 1'(gi)))    w_state_next = BUF_FREE;
            end

            always_ff @(posedge CLK) begin
                if (RESET) r_state <= BUF_FREE;
                else       r_state <= w_state_next;
            end

            assign w_free[gi]  = (r_state == BUF_FREE);
            assign w_ready[gi] = (r_state == BUF_READY);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
            r_rd_state <= w_rd_state_next;
        end
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        case (r_wr_state)
            W_IDLE: if (w_start)    w_wr_state_next = W_BUSY;
            W_BUSY: if (w_complete) w_wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        case (r_rd_state)
            R_IDLE: if (w_grant)   w_rd_state_next = R_BUSY;
            R_BUSY: if (w_release) w_rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        MIX_START  = w_start;
        WR_BUF_SEL = w_start ? w_start_buf : r_wr_buf;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_buf      <= 1'b0;
            r_rd_buf      <= 1'b0;
            r_ack         <= 1'b0;
            r_layer       <= '0;
            r_blink_idx   <= '0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_ack <= w_grant;
            if (w_grant) r_rd_buf <= w_grant_buf;
            if (w_start) begin
                r_wr_buf <= w_start_buf;
                r_layer  <= w_layer_frozen;
            end
            if (w_complete) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_blink_idx   <= (r_blink_idx == BLINK_LAST) ? '0 : r_blink_idx + BLINK_W'(1);
            end
            if (w_drop) r_drop_count <= sat_inc16(r_drop_count);
        end
    end

    assign LAYER_CONTROL  = r_layer;
    assign DISP_FRAME_ACK = r_ack;
    assign RD_BUF_SEL     = r_rd_buf;
    assign FRAME_COUNT    = r_frame_count;
    assign DROP_COUNT     = r_drop_count;
    assign SKIP_COUNT     = w_skip_count;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench for frame_buffer_scheduler: directed sequences, a blink table and
// randomized traffic against a frame-level reference model.
module tb_frame_buffer_scheduler;

    localparam int TB_BP = 4;
    localparam int TB_BO = 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] UPDATE_LIMIT = 32'd20;
    logic [3:0]  LAYER_CONTROL_REQ = 4'h0;
    logic        MIX_WRITE = 1'b0;
    logic [3:0]  MIX_ADDRESS = 4'd0;
    logic        DISP_FRAME_REQ = 1'b0;
    logic        DISP_FRAME_DONE = 1'b0;
    logic        MIX_START, WR_BUF_SEL, DISP_FRAME_ACK, RD_BUF_SEL;
    logic [3:0]  LAYER_CONTROL;
    logic [15:0] FRAME_COUNT, DROP_COUNT, SKIP_COUNT;

    int n_checks = 0;
    int n_errors = 0;

    frame_buffer_scheduler #(
        .X_LIMIT(4), .Y_LIMIT(4), .BLINK_PERIOD(TB_BP), .BLINK_OFF(TB_BO)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .UPDATE_LIMIT      (UPDATE_LIMIT),
        .LAYER_CONTROL_REQ (LAYER_CONTROL_REQ),
        .MIX_START         (MIX_START),
        .LAYER_CONTROL     (LAYER_CONTROL),
        .MIX_WRITE         (MIX_WRITE),
        .MIX_ADDRESS       (MIX_ADDRESS),
        .WR_BUF_SEL        (WR_BUF_SEL),
        .DISP_FRAME_REQ    (DISP_FRAME_REQ),
        .DISP_FRAME_ACK    (DISP_FRAME_ACK),
        .RD_BUF_SEL        (RD_BUF_SEL),
        .DISP_FRAME_DONE   (DISP_FRAME_DONE),
        .FRAME_COUNT       (FRAME_COUNT),
        .DROP_COUNT        (DROP_COUNT),
        .SKIP_COUNT        (SKIP_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mix_start"}, 64'(MIX_START), 64'd0);
        chk({tag, "_wr_sel"},    64'(WR_BUF_SEL), 64'd0);
        chk({tag, "_ack"},       64'(DISP_FRAME_ACK), 64'd0);
        chk({tag, "_rd_sel"},    64'(RD_BUF_SEL), 64'd0);
        chk({tag, "_layer"},     64'(LAYER_CONTROL), 64'd0);
        chk({tag, "_frames"},    64'(FRAME_COUNT), 64'd0);
        chk({tag, "_drops"},     64'(DROP_COUNT), 64'd0);
        chk({tag, "_skips"},     64'(SKIP_COUNT), 64'd0);
    endtask

    task automatic wait_start(input string tag, input int bound);
        int n;
        n = 0;
        while (!MIX_START && n < bound) begin
            cyc();
            n++;
        end
        chk({tag, "_mix_start_seen"}, 64'(MIX_START), 64'd1);
    endtask

    task automatic write_last();
        MIX_WRITE = 1'b1;
        MIX_ADDRESS = 4'd15;
        cyc();
        MIX_WRITE = 1'b0;
    endtask

    // Reference model: buffer ownership 0=free 1=being written 2=ready 3=on display
    int m_cnt, m_pend, m_skip, m_wbusy, m_wbuf, m_rbusy, m_rbuf, m_ack, m_layer, m_total, m_drops;
    int m_bs[2];

    task automatic model_reset();
        m_cnt = 0; m_pend = 0; m_skip = 0; m_wbusy = 0; m_wbuf = 0; m_rbusy = 0;
        m_rbuf = 0; m_ack = 0; m_layer = 0; m_total = 0; m_drops = 0;
        m_bs[0] = 0; m_bs[1] = 0;
    endtask

    function automatic int m_start();
        return (m_wbusy == 0 && m_pend != 0 && (m_bs[0] == 0 || m_bs[1] == 0)) ? 1 : 0;
    endfunction

    function automatic int m_sbuf();
        return (m_bs[0] == 0) ? 0 : 1;
    endfunction

    function automatic logic [63:0] m_expect();
        int wsel;
        wsel = (m_start() != 0) ? m_sbuf() : m_wbuf;
        return {8'd0, 1'(m_start()), 1'(wsel), 1'(m_ack), 1'(m_rbuf), 4'(m_layer),
                16'(m_total), 16'(m_drops), 16'(m_skip)};
    endfunction

    task automatic model_edge();
        int ul, tick, st, sb, cmp, oth, gr, gb, rel, drp;
        ul   = int'(UPDATE_LIMIT);
        tick = (ul <= 1 || m_cnt >= ul - 1) ? 1 : 0;
        st   = m_start();
        sb   = m_sbuf();
        cmp  = (m_wbusy != 0 && MIX_WRITE && MIX_ADDRESS == 4'd15) ? 1 : 0;
        oth  = 1 - m_wbuf;
        gr   = (m_rbusy == 0 && DISP_FRAME_REQ && (m_bs[0] == 2 || m_bs[1] == 2)) ? 1 : 0;
        gb   = (m_bs[1] == 2) ? 1 : 0;
        rel  = (m_rbusy != 0 && DISP_FRAME_DONE) ? 1 : 0;
        drp  = (cmp != 0 && m_bs[oth] == 2 && gr == 0) ? 1 : 0;
        if (st != 0) begin
            m_bs[sb] = 1; m_wbusy = 1; m_wbuf = sb;
            m_layer = int'(LAYER_CONTROL_REQ) & (((m_total % TB_BP) < TB_BO) ? 'hB : 'hF);
        end
        if (cmp != 0) begin m_bs[m_wbuf] = 2; m_wbusy = 0; m_total++; end
        if (drp != 0) begin m_bs[oth] = 0; if (m_drops < 65535) m_drops++; end
        if (gr != 0)  begin m_bs[gb] = 3; m_rbusy = 1; m_rbuf = gb; end
        if (rel != 0) begin m_bs[m_rbuf] = 0; m_rbusy = 0; end
        m_ack = gr;
        if (tick != 0 && m_pend != 0 && st == 0 && m_skip < 65535) m_skip++;
        m_pend = (tick != 0 || (m_pend != 0 && st == 0)) ? 1 : 0;
        m_cnt  = (tick != 0) ? 0 : m_cnt + 1;
    endtask

    task automatic do_reset(input logic [31:0] ul);
        RESET = 1'b1; UPDATE_LIMIT = ul; MIX_WRITE = 1'b0; MIX_ADDRESS = 4'd0;
        DISP_FRAME_REQ = 1'b0; DISP_FRAME_DONE = 1'b0;
        cyc(); cyc();
        model_reset();
        RESET = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_layer;
    } blink_vec_t;

    blink_vec_t bv[9];

    initial begin
        int n, cnt_ms, saw_ack;
        logic [15:0] s;
        int ul_tab[4];
        logic [63:0] act;

        // Directed: first frame, REQ held from reset
        LAYER_CONTROL_REQ = 4'hF;
        RESET = 1'b1; UPDATE_LIMIT = 32'd20;
        cyc(); cyc();
        chk_zero("reset");
        RESET = 1'b0;
        DISP_FRAME_REQ = 1'b1;
        n = 0; saw_ack = 0;
        while (!MIX_START && n < 40) begin
            cyc(); n++;
            if (DISP_FRAME_ACK) saw_ack = 1;
        end
        chk("s1_start_cycle", 64'(n), 64'd20);
        chk("s1_no_early_ack", 64'(saw_ack), 64'd0);
        chk("s1_wr_sel", 64'(WR_BUF_SEL), 64'd0);
        cyc();
        chk("s1_layer_frame0", 64'(LAYER_CONTROL), 64'hB);
        write_last();
        chk("s1_frames", 64'(FRAME_COUNT), 64'd1);
        chk("s1_ack_not_yet", 64'(DISP_FRAME_ACK), 64'd0);
        cyc();
        chk("s1_ack", 64'(DISP_FRAME_ACK), 64'd1);
        chk("s1_rd_sel", 64'(RD_BUF_SEL), 64'd0);
        DISP_FRAME_REQ = 1'b0;
        cyc();
        chk("s1_ack_pulse", 64'(DISP_FRAME_ACK), 64'd0);
        $display("s1: frame on buf0 granted to display, frames=%0d", FRAME_COUNT);

        // Display holds buf0; a frame completes on buf1; no FREE buffer remains
        wait_start("s2", 40);
        chk("s2_wr_sel", 64'(WR_BUF_SEL), 64'd1);
        cyc();
        write_last();
        chk("s2_frames", 64'(FRAME_COUNT), 64'd2);
        chk("s2_drops", 64'(DROP_COUNT), 64'd0);
        cnt_ms = 0;
        repeat (50) begin
            cyc();
            if (MIX_START) cnt_ms++;
        end
        chk("s2_start_withheld", 64'(cnt_ms), 64'd0);
        $display("s2: buf1 READY, buf0 on display, mixer start withheld");

        // Every-cycle ticks with both buffers held
        UPDATE_LIMIT = 32'd1;
        cyc();
        repeat (3) begin
            s = SKIP_COUNT;
            cyc();
            chk("s4_skip_step", 64'(SKIP_COUNT), 64'(s + 16'd1));
        end
        n = 0;
        while (SKIP_COUNT != 16'hFFFF && n < 70000) begin cyc(); n++; end
        chk("s4_skip_sat", 64'(SKIP_COUNT), 64'hFFFF);
        repeat (3) cyc();
        chk("s4_skip_hold", 64'(SKIP_COUNT), 64'hFFFF);
        $display("s4: skip counter saturated after %0d cycles", n);

        // DONE frees buf0 and the pending tick starts there on the next cycle
        DISP_FRAME_DONE = 1'b1;
        cyc();
        DISP_FRAME_DONE = 1'b0;
        chk("s2_done_start", 64'(MIX_START), 64'd1);
        chk("s2_done_wr_sel", 64'(WR_BUF_SEL), 64'd0);
        cyc();
        DISP_FRAME_REQ = 1'b1;
        cyc();
        chk("s2_ack_buf1", 64'(DISP_FRAME_ACK), 64'd1);
        chk("s2_rd_sel_buf1", 64'(RD_BUF_SEL), 64'd1);
        $display("s2: done on buf0 restarted mixer, buf1 granted");

        // Reset while both FSMs are busy
        RESET = 1'b1; UPDATE_LIMIT = 32'd20; MIX_WRITE = 1'b1; MIX_ADDRESS = 4'd15;
        cyc();
        chk_zero("rst_mid");
        RESET = 1'b0;
        saw_ack = 0;
        repeat (5) begin
            cyc();
            if (DISP_FRAME_ACK || MIX_START) saw_ack = 1;
        end
        chk("rst_no_activity", 64'(saw_ack), 64'd0);
        chk("rst_frames", 64'(FRAME_COUNT), 64'd0);
        MIX_WRITE = 1'b0; DISP_FRAME_REQ = 1'b0;
        $display("rst: mid-frame reset returned to idle");

        // Unseen READY frame is dropped when the next one completes
        do_reset(32'd3);
        wait_start("s3_a", 20);
        chk("s3_wr_sel_a", 64'(WR_BUF_SEL), 64'd0);
        cyc();
        write_last();
        wait_start("s3_b", 20);
        chk("s3_wr_sel_b", 64'(WR_BUF_SEL), 64'd1);
        cyc();
        write_last();
        chk("s3_drops", 64'(DROP_COUNT), 64'd1);
        chk("s3_frames", 64'(FRAME_COUNT), 64'd2);
        DISP_FRAME_REQ = 1'b1;
        cyc();
        chk("s3_ack", 64'(DISP_FRAME_ACK), 64'd1);
        chk("s3_rd_sel", 64'(RD_BUF_SEL), 64'd1);
        DISP_FRAME_REQ = 1'b0;
        $display("s3: buf0 dropped, buf1 granted, drops=%0d", DROP_COUNT);

        // Blink table: frames 0,4,8 lose the eye layer
        bv[0] = '{4'hF, 4'hB}; bv[1] = '{4'hF, 4'hF}; bv[2] = '{4'hF, 4'hF};
        bv[3] = '{4'hF, 4'hF}; bv[4] = '{4'h4, 4'h0}; bv[5] = '{4'h4, 4'h4};
        bv[6] = '{4'h3, 4'h3}; bv[7] = '{4'hC, 4'hC}; bv[8] = '{4'hF, 4'hB};
        do_reset(32'd2);
        for (int i = 0; i < 9; i++) begin
            LAYER_CONTROL_REQ = bv[i].req;
            wait_start($sformatf("blink%0d", i), 20);
            cyc();
            chk($sformatf("blink%0d_layer", i), 64'(LAYER_CONTROL), 64'(bv[i].exp_layer));
            LAYER_CONTROL_REQ = ~bv[i].req;
            cyc();
            chk($sformatf("blink%0d_frozen", i), 64'(LAYER_CONTROL), 64'(bv[i].exp_layer));
            write_last();
            $display("blink frame %0d: req=%h layer=%h", i, bv[i].req, bv[i].exp_layer);
        end
        chk("blink_frames", 64'(FRAME_COUNT), 64'd9);
        chk("blink_drops", 64'(DROP_COUNT), 64'd8);

        // Randomized traffic against the reference model
        ul_tab[0] = 1; ul_tab[1] = 2; ul_tab[2] = 5; ul_tab[3] = 9;
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(32'(ul_tab[seg]));
            for (int c = 0; c < 800; c++) begin
                if (m_ack != 0) DISP_FRAME_REQ = 1'b0;
                else if (!DISP_FRAME_REQ && m_rbusy == 0)
                    DISP_FRAME_REQ = ($urandom_range(0, 3) == 0);
                DISP_FRAME_DONE   = ($urandom_range(0, 4) == 0);
                MIX_WRITE         = 1'($urandom_range(0, 1));
                MIX_ADDRESS       = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                LAYER_CONTROL_REQ = 4'($urandom);
                model_edge();
                cyc();
                act = {8'd0, MIX_START, WR_BUF_SEL, DISP_FRAME_ACK, RD_BUF_SEL, LAYER_CONTROL,
                       FRAME_COUNT, DROP_COUNT, SKIP_COUNT};
                chk($sformatf("rand_seg%0d_cyc%0d", seg, c), act, m_expect());
                if (n_errors > 40) break;
            end
            $display("random segment %0d: ul=%0d frames=%0d drops=%0d skips=%0d",
                     seg, ul_tab[seg], FRAME_COUNT, DROP_COUNT, SKIP_COUNT);
            if (n_errors > 40) break;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
